// File: rtl/xlen_pipe_addsub.sv
// Pipelined XLEN-bit adder/subtractor: one W=XLEN/STAGES-bit slice per stage, carry registered between stages.
// Latency: STAGES cycles from in_valid&in_ready to out_valid. Throughput is 1 op/cycle.
// Backpressure: out_ready=0 freezes the last stage. Upstream bubbles fill, then in_ready drops.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               synchronous drop of every in-flight operation; blocks acceptance that cycle
//   in_valid/in_ready   operand handshake (in1, in2, ci, add_sub)
//   out_valid/out_ready result handshake (sum, co, v, z)
module xlen_pipe_addsub #(
  parameter int XLEN   = 64,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            ci,
  input  logic            add_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] sum,
  output logic            co,
  output logic            v,
  output logic            z
);

  localparam int W = (STAGES >= 1) ? XLEN / STAGES : XLEN;

  generate
    if (STAGES < 1 || (XLEN % ((STAGES < 1) ? 1 : STAGES)) != 0) begin : g_param_check
      $fatal(1, "xlen_pipe_addsub: XLEN must be a multiple of STAGES and STAGES >= 1");
    end
  endgenerate

  // Per-stage state. a_q/b_q carry the operands (b already conditionally
  // inverted), s_q the sum bits produced so far, c_q the carry into the next slice.
  logic [STAGES-1:0]           vld_q;
  logic [STAGES-1:0][XLEN-1:0] a_q;
  logic [STAGES-1:0][XLEN-1:0] b_q;
  logic [STAGES-1:0][XLEN-1:0] s_q;
  logic [STAGES-1:0]           c_q;
  logic                        v_q;
  logic                        z_q;

  // Stage load enables and the values each stage would capture.
  logic [STAGES-1:0]           ld;
  logic [STAGES-1:0]           src_vld;
  logic [STAGES-1:0][XLEN-1:0] src_a;
  logic [STAGES-1:0][XLEN-1:0] src_b;
  logic [STAGES-1:0][XLEN-1:0] src_s;
  logic [STAGES-1:0]           src_c;
  logic [STAGES-1:0][XLEN-1:0] nxt_s;
  logic [STAGES-1:0]           nxt_c;
  logic [W:0]                  slice_sum;
  logic                        nxt_v;
  logic                        nxt_z;

  // A stage loads when empty or when its occupant moves on. Since a full
  // stage moves on exactly when the next stage loads, ld[k] reduces to
  // ~vld_q[k] | ld[k+1]; the chain is combinational back from out_ready.
  always_comb begin
    ld = '0;
    ld[STAGES-1] = ~vld_q[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      ld[k] = ~vld_q[k] | ld[k+1];
    end
    in_ready = ld[0] & ~flush & ~rst;
  end

  always_comb begin
    src_vld   = '0;
    src_a     = '0;
    src_b     = '0;
    src_s     = '0;
    src_c     = '0;
    nxt_s     = '0;
    nxt_c     = '0;
    slice_sum = '0;

    // Subtract is A + ~B + ~borrow_in, so the effective carry-in is ci ^ add_sub.
    src_vld[0] = in_valid & in_ready;
    src_a[0]   = in1;
    src_b[0]   = add_sub ? ~in2 : in2;
    src_c[0]   = ci ^ add_sub;
    src_s[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_c[k]   = c_q[k-1];
      src_s[k]   = s_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      slice_sum = {1'b0, src_a[k][k*W +: W]} + {1'b0, src_b[k][k*W +: W]}
                + {{W{1'b0}}, src_c[k]};
      nxt_s[k]          = src_s[k];
      nxt_s[k][k*W +: W] = slice_sum[W-1:0];
      nxt_c[k]          = slice_sum[W];
    end

    // Flags only become known once the top slice is done.
    nxt_v = (src_a[STAGES-1][XLEN-1] == src_b[STAGES-1][XLEN-1])
          & (nxt_s[STAGES-1][XLEN-1] != src_a[STAGES-1][XLEN-1]);
    nxt_z = ~|nxt_s[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      v_q   <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush) begin
          vld_q[k] <= 1'b0;
        end else if (ld[k]) begin
          vld_q[k] <= src_vld[k];
        end
        // Data only moves with a valid beat, so idle-cycle operand X never lands here.
        if (ld[k] && src_vld[k]) begin
          a_q[k] <= src_a[k];
          b_q[k] <= src_b[k];
          s_q[k] <= nxt_s[k];
          c_q[k] <= nxt_c[k];
        end
      end
      if (ld[STAGES-1] && src_vld[STAGES-1]) begin
        v_q <= nxt_v;
        z_q <= nxt_z;
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign co        = c_q[STAGES-1];
  assign v         = v_q;
  assign z         = z_q;

  // Operand bits below the slice already consumed, and the last stage's
  // operand copies apart from their MSBs, are intentionally dead.
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q, src_a, src_b};

endmodule

// File: doc/xlen_pipe_addsub.md
Name: xlen_pipe_addsub

Overview:
Parametrised, pipelined XLEN-bit adder/subtractor with valid/ready handshakes on input and output. The operand width is split into STAGES equal slices. Each pipeline stage adds one slice and registers the carry into the next stage. It returns sum, carry-out, true signed overflow and a zero flag. It replaces the single-cycle ripple adder in the ALU datapath where XLEN=64 timing cannot close in one cycle.

Parameters:
XLEN, 64, operand/result width in bits
STAGES, 4, pipeline depth and number of carry slices; XLEN % STAGES == 0 required (elaboration error otherwise); STAGES >= 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of all in-flight operations
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat this cycle
in1  input  XLEN  operand A
in2  input  XLEN  operand B
ci  input  1  carry-in (add) / borrow-in (sub)
add_sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts the result
sum  output  XLEN  result
co  output  1  carry-out of MSB (sub: 1 = no borrow)
v  output  1  signed two's-complement overflow
z  output  1  sum == 0

Behaviour:
- Arithmetic:
  - add: sum = in1 + in2 + ci.
  - sub: sum = in1 - in2 - ci, implemented as in1 + ~in2 + ~ci.
  - co = carry out of bit XLEN-1.
  - v = (A[XLEN-1] == B'[XLEN-1]) & (sum[XLEN-1] != A[XLEN-1]), where B' = add_sub ? ~in2 : in2.
  - z = ~|sum. All modulo 2^XLEN.
- Slicing: W = XLEN/STAGES.
  - Stage k (0-based) computes bits [k*W +: W] using the carry registered from stage k-1. Stage 0 uses the effective carry-in.
  - Un-processed upper operand bits and already-produced lower sum bits travel alongside in the stage registers.
  - Only stage STAGES-1 computes v and z.
- Pipeline: each stage holds a valid bit.
  - A stage loads when it is empty or its contents advance this cycle.
  - The last stage advances when out_valid & out_ready.
  - in_ready = stage-0 load condition, which is combinational from out_ready through the valid chain. No bubble is inserted. Full throughput is 1 op/cycle.
- Latency: a beat accepted at cycle t (in_valid & in_ready) appears with out_valid=1 at cycle t+STAGES when there is no backpressure.
- Backpressure: out_valid=1 & out_ready=0 freezes the last stage. sum/co/v/z must hold stable until the handshake. Upstream stages fill any bubbles, then stall. in_ready=0 once all STAGES are full and stalled.
- Ordering: results emerge strictly in acceptance order. No beat is dropped or duplicated.
- Simultaneous events: with a full pipe and out_ready=1, a new beat is accepted in the same cycle the oldest leaves.
- flush: on the next rising edge all stage valid bits clear and out_valid=0. A beat presented in the same cycle as flush is not accepted (in_ready forced 0 while flush=1). Data registers need not clear.
- Reset: asynchronous assert of rst immediately clears all valid bits. Reset values:
  - out_valid=0, sum=0, co=0, v=0, z=0
  - in_ready=0 while rst=1, in_ready=1 on the first cycle after release
- Reset mid-operation: in-flight beats are discarded and never emitted.
- STAGES=1: degenerates to a registered single-stage adder with latency 1 and the same handshake.
- Input signals are sampled only when in_valid & in_ready; X on operands otherwise must not propagate into valid state.

Test Plan:
- Reset: assert rst mid-cycle with 3 beats in flight -> out_valid=0, sum=0, flags 0 immediately; after release, in_ready=1 and none of the 3 beats ever appears.
- Add carry chain (XLEN=64, STAGES=4): in1=0xFFFF_FFFF_FFFF_FFFF, in2=0, ci=1, add_sub=0 -> after exactly 4 cycles, sum=0, co=1, v=0, z=1 (carry crosses every slice boundary).
- Signed overflow: sub, in1=0x8000_0000_0000_0000, in2=1, ci=0 -> sum=0x7FFF_FFFF_FFFF_FFFF, co=1, v=1, z=0. Add 0x7FFF_FFFF_FFFF_FFFF+1 -> sum=0x8000_0000_0000_0000, co=0, v=1.
- Borrow-in: sub, in1=5, in2=5, ci=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, co=0, v=0, z=0.
- Throughput/backpressure: 10 back-to-back beats (in1=i, in2=i, add), out_ready held 0 for cycles 6-9 -> in_ready drops after 4 stalled beats, outputs stay stable, all 10 results 2i arrive in order with none lost.
- Flush: 3 beats in flight, flush=1 for one cycle with in_valid=1 -> in_ready=0 that cycle, no output from those beats, next accepted beat emerges after 4 cycles.
